// File: rtl/mem_ctrl.sv
// mem_ctrl: memory-side responder for the load/store buffer and the
// instruction fetcher.
//
// Each accepted 1, 2 or 4 byte access is serialised into byte transfers
// over an 8-bit RAM/IO port. A data request takes priority over a fetch.
// Loads and fetches return little-endian, zero-extended read data. Stores
// return a completion. Both are reported with a one-cycle done pulse.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   rdy             global enable; low freezes all state
//   flush           aborts reads and suppresses a pending read done
//   if_req/if_addr  fetch request (level) and word address
//   lsu_*           data request (lsu_empty == 0 means valid), size, data
//   stall           busy; requesters must not issue
//   done, done_instr, done_store, rdata   response bus
//   mem_din/mem_dout/mem_a/mem_wr         8-bit RAM/IO port (1-cycle read latency)
//   io_buffer_full  back-pressure for writes into the IO region
module mem_ctrl #(
  parameter int         AddrWidth = 32,
  parameter logic [1:0] IoHiBits  = 2'b11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 flush,
  input  logic                 if_req,
  input  logic [AddrWidth-1:0] if_addr,
  input  logic                 lsu_empty,
  input  logic                 lsu_store,
  input  logic [1:0]           lsu_size,
  input  logic [AddrWidth-1:0] lsu_addr,
  input  logic [31:0]          lsu_wdata,
  output logic                 stall,
  output logic                 done,
  output logic                 done_instr,
  output logic                 done_store,
  output logic [31:0]          rdata,
  input  logic [7:0]           mem_din,
  output logic [7:0]           mem_dout,
  output logic [AddrWidth-1:0] mem_a,
  output logic                 mem_wr,
  input  logic                 io_buffer_full
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state_q;
  logic [AddrWidth-1:0] addr_q;
  logic [AddrWidth-1:0] mem_a_q;
  logic [31:0]          wdata_q;
  logic [31:0]          rdata_q;
  logic [2:0]           size_q;
  logic [2:0]           cnt_q;
  logic                 instr_q;
  logic                 store_q;
  logic                 stall_q;
  logic                 done_q;
  logic                 mem_wr_q;
  logic [7:0]           mem_dout_q;

  logic [2:0]           cnt_inc;
  logic [1:0]           cap_idx;
  logic [AddrWidth-1:0] next_a;
  logic                 io_block;

  function automatic logic [2:0] size_bytes(input logic [1:0] s);
    case (s)
      2'b01:   return 3'd1;
      2'b10:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  assign cnt_inc = cnt_q + 3'd1;
  // In READ, the byte arriving now was addressed one cycle earlier.
  assign cap_idx = cnt_q[1:0] - 2'd1;
  // Natural modulo-2^AddrWidth wrap of the byte address.
  assign next_a  = addr_q + AddrWidth'(cnt_inc);
  // Only meaningful while a write byte is on the port (mem_wr_q gates it).
  assign io_block = (mem_a_q[17:16] == IoHiBits) && io_buffer_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      mem_a_q    <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      size_q     <= '0;
      cnt_q      <= '0;
      instr_q    <= 1'b0;
      store_q    <= 1'b0;
      stall_q    <= 1'b0;
      done_q     <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_dout_q <= '0;
    end else if (rdy) begin
      case (state_q)
        IDLE: begin
          if (!flush && (!lsu_empty || if_req)) begin
            cnt_q   <= '0;
            rdata_q <= '0;
            stall_q <= 1'b1;
            if (!lsu_empty) begin
              addr_q  <= lsu_addr;
              mem_a_q <= lsu_addr;
              size_q  <= size_bytes(lsu_size);
              wdata_q <= lsu_wdata;
              instr_q <= 1'b0;
              store_q <= lsu_store;
              if (lsu_store) begin
                // First write byte goes out in the very next cycle.
                state_q    <= WRITE;
                mem_wr_q   <= 1'b1;
                mem_dout_q <= lsu_wdata[7:0];
              end else begin
                state_q <= READ;
              end
            end else begin
              addr_q  <= if_addr;
              mem_a_q <= if_addr;
              size_q  <= 3'd4;
              instr_q <= 1'b1;
              store_q <= 1'b0;
              state_q <= READ;
            end
          end
        end
        READ: begin
          if (flush) begin
            state_q <= IDLE;
            stall_q <= 1'b0;
          end else begin
            // cnt_q counts address cycles issued; it runs one past size_q
            // to collect the final byte through the RAM's read latency.
            if (cnt_q != 3'd0) begin
              rdata_q[{cap_idx, 3'b000} +: 8] <= mem_din;
            end
            if (cnt_q == size_q) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_inc;
              if (cnt_inc < size_q) begin
                mem_a_q <= next_a;
              end
            end
          end
        end
        WRITE: begin
          // A blocked IO byte is retried every cycle without advancing.
          if (!io_block) begin
            if (cnt_inc == size_q) begin
              state_q  <= DONE;
              mem_wr_q <= 1'b0;
              done_q   <= 1'b1;
            end else begin
              cnt_q      <= cnt_inc;
              mem_a_q    <= next_a;
              mem_dout_q <= wdata_q[{cnt_inc[1:0], 3'b000} +: 8];
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          stall_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // A flush arriving during the done cycle cancels a read response;
  // store completions are always reported.
  assign done       = done_q && !(flush && !store_q);
  assign done_instr = done && instr_q;
  assign done_store = done && store_q;
  assign stall      = stall_q;
  assign rdata      = rdata_q;
  assign mem_a      = mem_a_q;
  assign mem_dout   = mem_dout_q;
  assign mem_wr     = mem_wr_q && rdy && !io_block;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed scenarios followed by random
// transactions, checked against a byte-level memory model.
module tb_mem_ctrl;

  localparam int K_LOAD  = 0;
  localparam int K_STORE = 1;
  localparam int K_FETCH = 2;

  logic        clk = 1'b0;
  logic        rst, rdy, flush, if_req, lsu_empty, lsu_store, io_buffer_full;
  logic [31:0] if_addr, lsu_addr, lsu_wdata, rdata, mem_a;
  logic [1:0]  lsu_size;
  logic        stall, done, done_instr, done_store, mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din = 8'h00;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int txn_id   = 0;

  // ram: what the DUT actually wrote; gold: what the requests say memory holds.
  logic [7:0] ram  [logic [31:0]];
  logic [7:0] gold [logic [31:0]];

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .if_req(if_req), .if_addr(if_addr),
    .lsu_empty(lsu_empty), .lsu_store(lsu_store), .lsu_size(lsu_size),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .stall(stall), .done(done), .done_instr(done_instr), .done_store(done_store),
    .rdata(rdata), .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a),
    .mem_wr(mem_wr), .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'hA5;
  endfunction

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return init_byte(a);
  endfunction

  function automatic logic [7:0] gold_rd(input logic [31:0] a);
    if (gold.exists(a)) return gold[a];
    return init_byte(a);
  endfunction

  function automatic int nbytes(input logic [1:0] s);
    if (s == 2'b01) return 1;
    if (s == 2'b10) return 2;
    return 4;
  endfunction

  // Synchronous RAM with one cycle of read latency.
  always @(posedge clk) begin : ram_model
    logic [7:0] v;
    v = ram_rd(mem_a);
    if (mem_wr) ram[mem_a] = mem_dout;
    mem_din <= v;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request from issue to response. flush_at = cycle (1 = first cycle
  // after acceptance) in which flush is pulsed, 0 for none. io_mode:
  // 0 = IO buffer never full, 1 = random, 2 = full for the first 3 cycles.
  task automatic run_txn(input int kind, input logic [31:0] a, input logic [1:0] sz,
                         input logic [31:0] wd, input int flush_at, input bit bg_fetch,
                         input int io_mode);
    int          n, exp_done, written, wait_c, done_c;
    logic [31:0] exp_rdata, ba;
    bit          aborted, finished, blocked;
    n         = (kind == K_FETCH) ? 4 : nbytes(sz);
    aborted   = (kind != K_STORE) && (flush_at > 0);
    exp_rdata = '0;
    if (kind != K_STORE) begin
      for (int j = 0; j < n; j++) exp_rdata[8*j +: 8] = gold_rd(a + 32'(j));
    end else begin
      for (int j = 0; j < n; j++) gold[a + 32'(j)] = 8'(wd >> (8*j));
    end
    wait_c = 0;
    while (stall !== 1'b0 && wait_c < 50) begin
      @(negedge clk);
      wait_c++;
    end
    check("idle_before_req", 32'(stall), 32'd0);
    if (kind == K_FETCH) begin
      if_req  = 1'b1;
      if_addr = a;
    end else begin
      lsu_empty = 1'b0;
      lsu_store = (kind == K_STORE);
      lsu_size  = sz;
      lsu_addr  = a;
      lsu_wdata = wd;
      if (bg_fetch) begin
        if_req  = 1'b1;
        if_addr = 32'h0;
      end
    end
    exp_done = (kind == K_STORE) ? 0 : n + 2;
    written  = 0;
    finished = 1'b0;
    done_c   = 0;
    for (int c = 1; c <= 40 && !finished; c++) begin
      @(posedge clk);
      #1;
      lsu_empty = 1'b1;
      flush     = (c == flush_at);
      if (flush && kind == K_FETCH) if_req = 1'b0;
      case (io_mode)
        1:       io_buffer_full = 1'($urandom_range(0, 1));
        2:       io_buffer_full = (c <= 3);
        default: io_buffer_full = 1'b0;
      endcase
      @(negedge clk);
      if (kind == K_STORE && written < n) begin
        ba      = a + 32'(written);
        blocked = io_buffer_full && (ba[17:16] == 2'b11);
        check("wr_en", 32'(mem_wr), 32'(!blocked));
        check("stall_busy", 32'(stall), 32'd1);
        check("done_early", 32'(done), 32'd0);
        if (!blocked) begin
          check("wr_addr", mem_a, ba);
          check("wr_data", 32'(mem_dout), 32'(8'(wd >> (8*written))));
          written++;
          if (written == n) exp_done = c + 1;
        end
      end else if (aborted) begin
        check("flush_no_done", 32'(done), 32'd0);
        check("rd_nowr", 32'(mem_wr), 32'd0);
        if (c <= n && c <= flush_at) check("rd_addr", mem_a, a + 32'(c - 1));
        if (c == flush_at + 1) check("flush_stall_drop", 32'(stall), 32'd0);
        if (c == n + 3) begin
          finished = 1'b1;
          done_c   = -1;
        end
      end else if (c == exp_done) begin
        check("done", 32'(done), 32'd1);
        check("done_instr", 32'(done_instr), 32'(kind == K_FETCH));
        check("done_store", 32'(done_store), 32'(kind == K_STORE));
        check("rdata", rdata, exp_rdata);
        done_c = c;
        if (kind == K_FETCH) if_req = 1'b0;
      end else if (exp_done > 0 && c == exp_done + 1) begin
        check("done_one_cycle", 32'(done), 32'd0);
        finished = 1'b1;
      end else begin
        check("done_early", 32'(done), 32'd0);
        check("stall_busy", 32'(stall), 32'd1);
        check("rd_nowr", 32'(mem_wr), 32'd0);
        if (c <= n) check("rd_addr", mem_a, a + 32'(c - 1));
      end
    end
    check("txn_complete", 32'(finished), 32'd1);
    flush          = 1'b0;
    io_buffer_full = 1'b0;
    $display("txn %0d kind=%0d addr=%h bytes=%0d flush_at=%0d done_cycle=%0d",
             txn_id, kind, a, n, flush_at, done_c);
    txn_id++;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; if_req = 1'b0; if_addr = '0;
    lsu_empty = 1'b1; lsu_store = 1'b0; lsu_size = '0; lsu_addr = '0;
    lsu_wdata = '0; io_buffer_full = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ram[32'h100 + 32'(i)]  = 8'(8'h11 * (i + 1));
      gold[32'h100 + 32'(i)] = 8'(8'h11 * (i + 1));
    end

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_done_tags", {30'd0, done_instr, done_store}, 32'd0);
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_mem_a", mem_a, 32'd0);
    check("rst_mem_dout", 32'(mem_dout), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    // LW from preloaded 11 22 33 44 -> 0x44332211.
    run_txn(K_LOAD, 32'h100, 2'b00, 32'h0, 0, 1'b0, 0);
    // SB: only one byte written, neighbour untouched.
    run_txn(K_STORE, 32'h205, 2'b01, 32'hAABBCCDD, 0, 1'b0, 0);
    check("sb_byte", 32'(ram_rd(32'h205)), 32'h0000_00DD);
    check("sb_neighbour", 32'(ram_rd(32'h206)), 32'(init_byte(32'h206)));
    // Data request wins over a simultaneous fetch; fetch follows.
    run_txn(K_LOAD, 32'h10, 2'b10, 32'h0, 0, 1'b1, 0);
    run_txn(K_FETCH, 32'h0, 2'b00, 32'h0, 0, 1'b0, 0);
    // Flush in cycle 2 of a fetch, then a byte load.
    run_txn(K_FETCH, 32'h40, 2'b00, 32'h0, 2, 1'b0, 0);
    run_txn(K_LOAD, 32'h41, 2'b01, 32'h0, 0, 1'b0, 0);
    // Flush in the done cycle of a load suppresses the response.
    run_txn(K_LOAD, 32'h120, 2'b01, 32'h0, 3, 1'b0, 0);
    // Flush during a store is ignored.
    run_txn(K_STORE, 32'h130, 2'b10, 32'h0000_BEEF, 1, 1'b0, 0);
    // IO write held for three cycles.
    run_txn(K_STORE, 32'h0003_0000, 2'b01, 32'h0000_005A, 0, 1'b0, 2);
    check("io_byte", 32'(ram_rd(32'h0003_0000)), 32'h0000_005A);

    // rdy low: nothing is accepted, no write strobe.
    rdy = 1'b0; lsu_empty = 1'b0; lsu_store = 1'b1; lsu_size = 2'b00;
    lsu_addr = 32'h500; lsu_wdata = 32'h0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rdy_low_stall", 32'(stall), 32'd0);
      check("rdy_low_wr", 32'(mem_wr), 32'd0);
    end
    lsu_empty = 1'b1; rdy = 1'b1;
    @(negedge clk);

    // Reset during byte 2 of a word store.
    lsu_empty = 1'b0; lsu_store = 1'b1; lsu_size = 2'b00;
    lsu_addr = 32'h400; lsu_wdata = 32'h12345678;
    @(posedge clk);
    #1 lsu_empty = 1'b1;
    @(negedge clk);
    check("sw_byte1_wr", 32'(mem_wr), 32'd1);
    @(posedge clk);
    #2 check("sw_byte2_wr", 32'(mem_wr), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_async_wr", 32'(mem_wr), 32'd0);
    check("rst_async_stall", 32'(stall), 32'd0);
    check("rst_async_done", 32'(done), 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_hold_wr", 32'(mem_wr), 32'd0);
    end
    rst = 1'b0;
    gold[32'h400] = 8'h78;
    check("rst_sw_byte0", 32'(ram_rd(32'h400)), 32'h0000_0078);
    check("rst_sw_byte1", 32'(ram_rd(32'h401)), 32'(init_byte(32'h401)));
    @(negedge clk);
    run_txn(K_LOAD, 32'h400, 2'b00, 32'h0, 0, 1'b0, 0);

    // Random traffic: small shared region, wrap-around, IO region, anywhere.
    for (int t = 0; t < 40; t++) begin
      int          kind, rsel, fl, n;
      logic [31:0] a;
      logic [1:0]  sz;
      kind = int'($urandom_range(0, 2));
      sz   = 2'($urandom_range(0, 3));
      rsel = int'($urandom_range(0, 3));
      case (rsel)
        0:       a = 32'h100 + $urandom_range(0, 63);
        1:       a = 32'hFFFF_FFFC + $urandom_range(0, 3);
        2:       a = 32'h0003_0000 + $urandom_range(0, 15);
        default: a = $urandom;
      endcase
      n  = (kind == K_FETCH) ? 4 : nbytes(sz);
      fl = 0;
      if ($urandom_range(0, 3) == 0)
        fl = int'($urandom_range(1, (kind == K_STORE) ? n + 1 : n + 2));
      run_txn(kind, a, sz, $urandom, fl, 1'b0, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
